// File: rtl/fifo_burst_drain_controller_pkg.sv
// Shared types and helpers for the FIFO burst drain controller.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        CLEAR = 2'd3
    } drain_state_t;

    localparam int BURSTS_DONE_WIDTH = 16;
    localparam int LEN_CALC_WIDTH    = 32;

    // A zero burst length still moves one word so the stream always sees a last beat.
    function automatic logic [LEN_CALC_WIDTH-1:0] effective_len(input logic [LEN_CALC_WIDTH-1:0] burst_len);
        return (burst_len == '0) ? LEN_CALC_WIDTH'(1) : burst_len;
    endfunction

endpackage

// File: rtl/fifo_burst_drain_controller_if.sv
// Valid/ready output stream with last marker, from the drain controller to the packetiser.
interface fifo_burst_drain_controller_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/fifo_burst_drain_controller_timeout.sv
// Saturating idle counter that flags when it has reached a nonzero threshold.
module drain_timeout_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             count_en,
    input  logic [WIDTH-1:0] threshold,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    assign expired = (threshold != '0) && (count >= threshold);

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (count_en && !expired)
            count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/fifo_burst_drain_controller.sv
// Drains programmed bursts from the show-ahead sample FIFO onto a valid/ready stream.
// Optional partial-burst timeout: define FIFO_DRAIN_TIMEOUT_EN.
module fifo_burst_drain_controller
    import fifo_drain_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sw_clear,
    input  logic [ADDRESS_WIDTH-1:0]     burst_len,
    input  logic [TIMEOUT_WIDTH-1:0]     timeout_cycles,
    input  logic [ADDRESS_WIDTH-1:0]     fifo_data_count,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_read_data,
    output logic                         fifo_read_increment,
    output logic                         fifo_clear,
    fifo_burst_drain_controller_if.master out_stream,
    output logic                         busy,
    output logic                         burst_aborted,
    output logic [BURSTS_DONE_WIDTH-1:0] bursts_done
);
    localparam int OW = ADDRESS_WIDTH + 1;

    drain_state_t  state;
    logic [OW-1:0] burst_remaining;
    logic [OW-1:0] occ;
    logic [OW-1:0] len;
    logic          in_burst;
    logic          accept;
    logic          last_accept;
    logic          aborted_q;
    logic          timeout_hit;

    // Count reads 0 at full, so the full flag supplies the missing top bit.
    assign occ = fifo_full ? {1'b1, {ADDRESS_WIDTH{1'b0}}} : {1'b0, fifo_data_count};
    assign len = OW'(effective_len(LEN_CALC_WIDTH'(burst_len)));

    assign in_burst    = (state == BURST);
    assign accept      = out_stream.out_valid && out_stream.out_ready;
    assign last_accept = accept && (burst_remaining == OW'(1));

    assign out_stream.out_valid = in_burst && !fifo_empty;
    assign out_stream.out_data  = in_burst ? fifo_read_data : '0;
    assign out_stream.out_last  = out_stream.out_valid && (burst_remaining == OW'(1));

    assign fifo_read_increment = accept;
    assign fifo_clear          = (state == CLEAR);
    assign busy                = (state == BURST) || (state == CLEAR);
    assign burst_aborted       = (state == CLEAR) && aborted_q;

`ifdef FIFO_DRAIN_TIMEOUT_EN
    logic wait_partial;
    logic tmo_clear;
    logic tmo_expired;

    assign wait_partial = (state == WAIT) && enable && (occ != '0) && (occ < len);
    assign tmo_clear    = (state != WAIT) || (occ == '0) || (occ >= len);
    assign timeout_hit  = wait_partial && tmo_expired;

    drain_timeout_counter #(.WIDTH(TIMEOUT_WIDTH)) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clear     (tmo_clear),
        .count_en  (wait_partial),
        .threshold (timeout_cycles),
        .expired   (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            burst_remaining <= '0;
            bursts_done     <= '0;
            aborted_q       <= 1'b0;
        end else begin
            aborted_q <= sw_clear && in_burst && !last_accept;
            if (last_accept)
                bursts_done <= bursts_done + BURSTS_DONE_WIDTH'(1);
            if (accept)
                burst_remaining <= burst_remaining - OW'(1);

            if (sw_clear) begin
                state <= CLEAR;
            end else begin
                case (state)
                    IDLE:  if (enable) state <= WAIT;
                    WAIT: begin
                        if (!enable) begin
                            state <= IDLE;
                        end else if (occ >= len) begin
                            burst_remaining <= len;
                            state           <= BURST;
                        end else if (timeout_hit) begin
                            burst_remaining <= occ;
                            state           <= BURST;
                        end
                    end
                    BURST: if (last_accept) state <= enable ? WAIT : IDLE;
                    CLEAR: state <= enable ? WAIT : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_drain_controller.sv
// Directed bench for fifo_burst_drain_controller with a queue-backed show-ahead FIFO model.
module tb_fifo_burst_drain_controller;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          sw_clear;
    logic [AW-1:0] burst_len;
    logic [TW-1:0] timeout_cycles;
    logic [AW-1:0] fifo_data_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_read_increment;
    logic          fifo_clear;
    logic          busy;
    logic          burst_aborted;
    logic [15:0]   bursts_done;

    fifo_burst_drain_controller_if #(.DATA_WIDTH(DW)) out_if ();

    fifo_burst_drain_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_WIDTH(TW)) dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .sw_clear            (sw_clear),
        .burst_len           (burst_len),
        .timeout_cycles      (timeout_cycles),
        .fifo_data_count     (fifo_data_count),
        .fifo_full           (fifo_full),
        .fifo_empty          (fifo_empty),
        .fifo_read_data      (fifo_read_data),
        .fifo_read_increment (fifo_read_increment),
        .fifo_clear          (fifo_clear),
        .out_stream          (out_if),
        .busy                (busy),
        .burst_aborted       (burst_aborted),
        .bursts_done         (bursts_done)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          inc_cnt;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] beat_data[$];
    logic          beat_last[$];

    task automatic drive_fifo();
        fifo_data_count = AW'(fq.size());
        fifo_full       = (fq.size() >= (1 << AW));
        fifo_empty      = (fq.size() == 0);
        fifo_read_data  = (fq.size() > 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        fq.push_back(d);
        drive_fifo();
        #1;
    endtask

    // One clock: log the handshake seen before the edge, then update the FIFO model.
    task automatic tick();
        logic inc, clr;
        #1;
        inc = fifo_read_increment;
        clr = fifo_clear;
        if (out_if.out_valid && out_if.out_ready) begin
            beat_data.push_back(out_if.out_data);
            beat_last.push_back(out_if.out_last);
        end
        if (inc) inc_cnt++;
        @(posedge clock);
        if (clr) fq.delete();
        else if (inc && fq.size() > 0) void'(fq.pop_front());
        @(negedge clock);
        drive_fifo();
        #1;
    endtask

    task automatic clear_log();
        beat_data.delete();
        beat_last.delete();
        inc_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; sw_clear = 1'b0; burst_len = AW'(4);
        timeout_cycles = '0; out_if.out_ready = 1'b1;
        fq.delete(); drive_fifo(); clear_log();
        push(16'h0AAA);
        tick(); tick();
        checks++;
        if ({out_if.out_valid, out_if.out_last, fifo_read_increment, fifo_clear, busy, burst_aborted} !== 6'b0) begin
            $display("FAIL reset_outputs: got %b want 000000",
                     {out_if.out_valid, out_if.out_last, fifo_read_increment, fifo_clear, busy, burst_aborted});
            errors++;
        end
        checks++;
        if (bursts_done !== 16'd0 || out_if.out_data !== 16'h0) begin
            $display("FAIL reset_counters: bursts_done=%0d data=%h want 0/0", bursts_done, out_if.out_data);
            errors++;
        end
        enable = 1'b0; reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || fq.size() != 1) begin
            $display("FAIL reset_idle: busy=%b fifo=%0d want 0/1", busy, fq.size());
            errors++;
        end
        fq.delete(); drive_fifo();
    endtask

    task automatic test_flush();
        sw_clear = 1'b1;
        tick();
        sw_clear = 1'b0;
        checks++;
        if (fifo_clear !== 1'b1 || busy !== 1'b1 || out_if.out_valid !== 1'b0) begin
            $display("FAIL flush_clear: clear=%b busy=%b valid=%b want 1/1/0", fifo_clear, busy, out_if.out_valid);
            errors++;
        end
        tick();
        checks++;
        if (fifo_clear !== 1'b0 || fq.size() != 0 || burst_aborted !== 1'b0) begin
            $display("FAIL flush_done: clear=%b fifo=%0d aborted=%b want 0/0/0", fifo_clear, fq.size(), burst_aborted);
            errors++;
        end
    endtask

    task automatic test_ramp();
        enable = 1'b1; burst_len = AW'(4); out_if.out_ready = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            push(16'h100 + 16'(i));
            if (i < 3) tick();
        end
        checks++;
        if (busy !== 1'b0 || out_if.out_valid !== 1'b0) begin
            $display("FAIL ramp_no_early_start: busy=%b valid=%b want 0/0", busy, out_if.out_valid);
            errors++;
        end
        tick();
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'h100 || busy !== 1'b1) begin
            $display("FAIL ramp_first_beat: valid=%b data=%h busy=%b want 1/0100/1", out_if.out_valid, out_if.out_data, busy);
            errors++;
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (beat_data.size() != 4 || inc_cnt != 4) begin
            $display("FAIL ramp_beats: beats=%0d incs=%0d want 4/4", beat_data.size(), inc_cnt);
            errors++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beat_data[i] !== 16'h100 + 16'(i) || beat_last[i] !== (i == 3)) begin
                    $display("FAIL ramp_beat%0d: data=%h last=%b want %h/%b", i, beat_data[i], beat_last[i],
                             16'h100 + 16'(i), (i == 3));
                    errors++;
                end
            end
        end
        checks++;
        if (bursts_done !== 16'd1 || busy !== 1'b0 || fq.size() != 0) begin
            $display("FAIL ramp_done: bursts=%0d busy=%b fifo=%0d want 1/0/0", bursts_done, busy, fq.size());
            errors++;
        end
    endtask

    task automatic test_stall();
        logic ready_seq [5];
        ready_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        burst_len = AW'(3);
        clear_log();
        for (int i = 0; i < 5; i++) fq.push_back(16'h200 + 16'(i));
        drive_fifo();
        tick();
        for (int i = 0; i < 5; i++) begin
            out_if.out_ready = ready_seq[i];
            if (i == 1 || i == 2) begin
                #1;
                checks++;
                if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'h201 || out_if.out_last !== 1'b0) begin
                    $display("FAIL stall_hold%0d: valid=%b data=%h last=%b want 1/0201/0", i,
                             out_if.out_valid, out_if.out_data, out_if.out_last);
                    errors++;
                end
            end
            tick();
        end
        out_if.out_ready = 1'b1;
        checks++;
        if (beat_data.size() != 3 || beat_data[0] !== 16'h200 || beat_data[1] !== 16'h201 || beat_data[2] !== 16'h202) begin
            $display("FAIL stall_beats: count=%0d want 3 words 0200..0202", beat_data.size());
            errors++;
        end
        checks++;
        if (beat_last.size() != 3 || beat_last[0] !== 1'b0 || beat_last[1] !== 1'b0 || beat_last[2] !== 1'b1) begin
            $display("FAIL stall_last: count=%0d want last only on beat 3", beat_last.size());
            errors++;
        end
        checks++;
        if (fq.size() != 2 || busy !== 1'b0 || bursts_done !== 16'd2) begin
            $display("FAIL stall_done: fifo=%0d busy=%b bursts=%0d want 2/0/2", fq.size(), busy, bursts_done);
            errors++;
        end
        test_flush();
    endtask

    task automatic test_full();
        burst_len = AW'(0);
        clear_log();
        for (int i = 0; i < 256; i++) fq.push_back(16'h3000 + 16'(i));
        drive_fifo();
        tick();
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_last !== 1'b1 || out_if.out_data !== 16'h3000) begin
            $display("FAIL full_single_beat: valid=%b last=%b data=%h want 1/1/3000",
                     out_if.out_valid, out_if.out_last, out_if.out_data);
            errors++;
        end
        tick();
        checks++;
        if (beat_data.size() != 1 || bursts_done !== 16'd3 || busy !== 1'b0) begin
            $display("FAIL full_done: beats=%0d bursts=%0d busy=%b want 1/3/0", beat_data.size(), bursts_done, busy);
            errors++;
        end
        test_flush();
    endtask

    task automatic test_abort();
        burst_len = AW'(8);
        clear_log();
        for (int i = 0; i < 8; i++) fq.push_back(16'h400 + 16'(i));
        drive_fifo();
        tick(); tick(); tick();
        sw_clear = 1'b1; out_if.out_ready = 1'b0;
        tick();
        sw_clear = 1'b0; out_if.out_ready = 1'b1;
        checks++;
        if (fifo_clear !== 1'b1 || burst_aborted !== 1'b1 || out_if.out_valid !== 1'b0) begin
            $display("FAIL abort_clear: clear=%b aborted=%b valid=%b want 1/1/0", fifo_clear, burst_aborted, out_if.out_valid);
            errors++;
        end
        tick();
        checks++;
        if (fifo_clear !== 1'b0 || burst_aborted !== 1'b0 || fq.size() != 0) begin
            $display("FAIL abort_pulse: clear=%b aborted=%b fifo=%0d want 0/0/0", fifo_clear, burst_aborted, fq.size());
            errors++;
        end
        checks++;
        if (beat_data.size() != 2 || beat_last[0] !== 1'b0 || beat_last[1] !== 1'b0 || bursts_done !== 16'd3) begin
            $display("FAIL abort_count: beats=%0d bursts=%0d want 2 beats no last, bursts 3", beat_data.size(), bursts_done);
            errors++;
        end
    endtask

    task automatic test_enable_drop();
        burst_len = AW'(4);
        clear_log();
        for (int i = 0; i < 8; i++) fq.push_back(16'h500 + 16'(i));
        drive_fifo();
        tick(); tick();
        enable = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (beat_data.size() != 4 || beat_last[3] !== 1'b1 || beat_data[3] !== 16'h503 || bursts_done !== 16'd4) begin
            $display("FAIL drop_complete: beats=%0d bursts=%0d want 4 beats last 0503, bursts 4", beat_data.size(), bursts_done);
            errors++;
        end
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || out_if.out_valid !== 1'b0 || beat_data.size() != 4 || fq.size() != 4) begin
            $display("FAIL drop_idle: busy=%b valid=%b beats=%0d fifo=%0d want 0/0/4/4",
                     busy, out_if.out_valid, beat_data.size(), fq.size());
            errors++;
        end
        test_flush();
        enable = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        burst_len = AW'(8); timeout_cycles = TW'(10);
        clear_log();
        for (int i = 0; i < 3; i++) fq.push_back(16'h600 + 16'(i));
        drive_fifo();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL timeout_early: busy=%b want 0", busy);
            errors++;
        end
        tick();
`ifdef FIFO_DRAIN_TIMEOUT_EN
        checks++;
        if (busy !== 1'b1 || out_if.out_data !== 16'h600) begin
            $display("FAIL timeout_start: busy=%b data=%h want 1/0600", busy, out_if.out_data);
            errors++;
        end
        tick(); tick(); tick();
        checks++;
        if (beat_data.size() != 3 || beat_last[0] !== 1'b0 || beat_last[1] !== 1'b0 || beat_last[2] !== 1'b1
            || bursts_done !== 16'd5) begin
            $display("FAIL timeout_burst: beats=%0d bursts=%0d want 3 beats last on 3rd, bursts 5",
                     beat_data.size(), bursts_done);
            errors++;
        end
`else
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || beat_data.size() != 0 || fq.size() != 3 || bursts_done !== 16'd4) begin
            $display("FAIL timeout_disabled: busy=%b beats=%0d fifo=%0d bursts=%0d want 0/0/3/4",
                     busy, beat_data.size(), fq.size(), bursts_done);
            errors++;
        end
`endif
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sw_clear = 1'b0; burst_len = '0; timeout_cycles = '0;
        out_if.out_ready = 1'b0; inc_cnt = 0;
        drive_fifo();
        @(negedge clock);
        test_reset();
        test_ramp();
        test_stall();
        test_full();
        test_abort();
        test_enable_drop();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
